// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART frame arbiter: sync byte, FSM states, frame length.
package uart_arb_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

  // Bytes on the wire per frame: sync + ID + payload (+ checksum).
  function automatic int frame_len(input int payload_bytes, input bit checksum_en);
    return payload_bytes + (checksum_en ? 3 : 2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_grant, wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = CW'(last_grant) + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[cand[IDX_W-1:0]] = 1'b1;
        index                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler framing one requester's payload at a time onto the UART, paced by uart_tx_busy.
// Grant one cycle after req_valid in IDLE, sync strobe the cycle after; UART_ARB_CHECKSUM_EN appends a checksum byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*PAYLOAD_BYTES*8-1:0] req_payload,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [7:0]                         uart_data,
  output logic                               uart_data_rdy,
  input  logic                               uart_tx_busy,
  output logic                               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 3);
  localparam int PL_W  = PAYLOAD_BYTES * 8;
  localparam int SR_W  = PL_W + 8;
`ifdef UART_ARB_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int               FRAME_LEN   = frame_len(PAYLOAD_BYTES, CHK_EN);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_PL_IDX = CNT_W'(PAYLOAD_BYTES + 1);

  arb_state_t                   state;
  logic [IDX_W-1:0]             last_grant;
  logic [IDX_W-1:0]             winner;
  logic [IDX_W-1:0]             arb_idx;
  logic [NUM_REQ-1:0]           arb_grant;
  logic [CNT_W-1:0]             counter;
  logic [CNT_W-1:0]             issue_idx;
  logic [SR_W-1:0]              shreg;
  logic [NUM_REQ-1:0][PL_W-1:0] payload_arr;
  logic                         issue;
  logic [7:0]                   issue_byte;
`ifdef UART_ARB_CHECKSUM_EN
  logic [7:0]                   csum;
`endif

  assign payload_arr = req_payload;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (arb_grant),
    .index     (arb_idx)
  );

  // Strobes are registered, so the byte is chosen one cycle ahead: on entry to
  // SEND (from GRANT or WAIT_DONE) or while SEND is holding on a busy UART.
  always_comb begin
    issue     = 1'b0;
    issue_idx = counter;
    case (state)
      GRANT: begin
        issue     = !uart_tx_busy;
        issue_idx = '0;
      end
      SEND: issue = !uart_tx_busy && !uart_data_rdy;
      WAIT_DONE: begin
        issue     = !uart_tx_busy && (counter != LAST_IDX);
        issue_idx = counter + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    issue_byte = shreg[SR_W-1 -: 8];
    if (issue_idx == '0) issue_byte = SYNC_BYTE;
`ifdef UART_ARB_CHECKSUM_EN
    else if (issue_idx == LAST_IDX) issue_byte = 8'h00 - csum;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_ready     <= '0;
      uart_data_rdy <= 1'b0;
      uart_data     <= 8'h00;
      busy          <= 1'b0;
      counter       <= '0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      winner        <= '0;
      shreg         <= '0;
`ifdef UART_ARB_CHECKSUM_EN
      csum          <= 8'h00;
`endif
    end else begin
      req_ready     <= '0;
      uart_data_rdy <= 1'b0;
      if (issue) begin
        uart_data_rdy <= 1'b1;
        uart_data     <= issue_byte;
        if (issue_idx != '0 && issue_idx <= LAST_PL_IDX) begin
          shreg <= {shreg[SR_W-9:0], 8'h00};
`ifdef UART_ARB_CHECKSUM_EN
          csum  <= csum + issue_byte;
`endif
        end
      end
      case (state)
        IDLE: begin
          if (|req_valid) begin
            winner     <= arb_idx;
            last_grant <= arb_idx;
            req_ready  <= arb_grant;
            busy       <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          shreg   <= {8'(winner), payload_arr[winner]};
          counter <= '0;
`ifdef UART_ARB_CHECKSUM_EN
          csum    <= 8'h00;
`endif
          state   <= SEND;
        end
        SEND: begin
          if (uart_data_rdy) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (uart_tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (counter == LAST_IDX) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              counter <= counter + CNT_W'(1);
              state   <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
